// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: chooser encoding, table defaults and the
// saturating chooser-counter update rule.
package bp_pkg;

    localparam logic CHOOSE_LOCAL  = 1'b0;
    localparam logic CHOOSE_GLOBAL = 1'b1;

    localparam int unsigned DEFAULT_CTR_BITS   = 2;
    localparam int unsigned DEFAULT_INDEX_BITS = 6;

    // Widest legal chooser counter; narrower counters are zero-extended into this.
    localparam int unsigned CTR_MAX_BITS = 4;

    function automatic logic [CTR_MAX_BITS-1:0] chooser_sat_next(
        input logic [CTR_MAX_BITS-1:0] ctr,
        input int unsigned             ctr_bits,
        input logic                    local_correct,
        input logic                    global_correct
    );
        logic [CTR_MAX_BITS-1:0] max_val;
        logic [CTR_MAX_BITS-1:0] next;
        max_val = CTR_MAX_BITS'((32'd1 << ctr_bits) - 32'd1);
        next    = ctr;
        if (global_correct && !local_correct && (ctr != max_val)) begin
            next = ctr + CTR_MAX_BITS'(1);
        end else if (local_correct && !global_correct && (ctr != '0)) begin
            next = ctr - CTR_MAX_BITS'(1);
        end
        return next;
    endfunction

endpackage

// File: rtl/chooser_ctr_next.sv
// Combinational saturating update of a single local/global chooser counter.
module chooser_ctr_next
    import bp_pkg::*;
#(
    parameter int unsigned CTR_BITS = DEFAULT_CTR_BITS
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                local_correct,
    input  logic                global_correct,
    output logic [CTR_BITS-1:0] ctr_next
);

    always_comb begin
        ctr_next = CTR_BITS'(chooser_sat_next(CTR_MAX_BITS'(ctr), CTR_BITS,
                                              local_correct, global_correct));
    end

endmodule

// File: rtl/tournament_chooser_table.sv
// Table of saturating chooser counters selecting between local and global
// predictions, with write-first forwarding and a registered 1-cycle lookup.
module tournament_chooser_table
    import bp_pkg::*;
#(
    parameter int unsigned CTR_BITS   = DEFAULT_CTR_BITS,
    parameter int unsigned INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter int unsigned INIT_VALUE = 2 ** (CTR_BITS - 1) - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_valid,
    input  logic [INDEX_BITS-1:0] pred_index,
    input  logic                  local_taken,
    input  logic                  global_taken,
    output logic                  pred_out_valid,
    output logic                  pred_use_global,
    output logic                  pred_taken,
    output logic [CTR_BITS-1:0]   pred_ctr,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_local_correct,
    input  logic                  upd_global_correct
);

    localparam int unsigned ENTRIES = 2 ** INDEX_BITS;

    if (CTR_BITS < 2 || CTR_BITS > CTR_MAX_BITS) begin : gen_bad_ctr_bits
        $error("tournament_chooser_table: CTR_BITS must be in 2..4");
    end

    logic [CTR_BITS-1:0] table_q [ENTRIES];

    logic [CTR_BITS-1:0] upd_ctr;
    logic [CTR_BITS-1:0] upd_next;
    logic [CTR_BITS-1:0] sel_ctr;
    logic                sel_use_global;
    logic                sel_taken;

    logic                out_valid_q;
    logic                use_global_q;
    logic                taken_q;
    logic [CTR_BITS-1:0] ctr_q;

    chooser_ctr_next #(
        .CTR_BITS(CTR_BITS)
    ) u_ctr_next (
        .ctr            (upd_ctr),
        .local_correct  (upd_local_correct),
        .global_correct (upd_global_correct),
        .ctr_next       (upd_next)
    );

    always_comb begin
        upd_ctr = table_q[upd_index];
        // Same-entry training this cycle is visible to the lookup (write-first).
        if (upd_valid && (upd_index == pred_index)) begin
            sel_ctr = upd_next;
        end else begin
            sel_ctr = table_q[pred_index];
        end
        sel_use_global = (sel_ctr[CTR_BITS-1] == CHOOSE_GLOBAL);
        sel_taken      = (sel_ctr[CTR_BITS-1] == CHOOSE_LOCAL) ? local_taken : global_taken;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= CTR_BITS'(INIT_VALUE);
            end
            out_valid_q  <= 1'b0;
            use_global_q <= 1'b0;
            taken_q      <= 1'b0;
            ctr_q        <= '0;
        end else begin
            if (upd_valid) begin
                table_q[upd_index] <= upd_next;
            end
            out_valid_q <= pred_valid;
            // Decision outputs hold their last value between lookups.
            if (pred_valid) begin
                use_global_q <= sel_use_global;
                taken_q      <= sel_taken;
                ctr_q        <= sel_ctr;
            end
        end
    end

    always_comb begin
        pred_out_valid  = out_valid_q;
        pred_use_global = use_global_q;
        pred_taken      = taken_q;
        pred_ctr        = ctr_q;
    end

endmodule

// File: tb/tb_tournament_chooser_table.sv
// Directed bench for tournament_chooser_table: default 2-bit instance plus a
// 3-bit instance sharing the same stimulus.
module tb_tournament_chooser_table;

    logic       clk;
    logic       rst;
    logic       pred_valid;
    logic [5:0] pred_index;
    logic       local_taken;
    logic       global_taken;
    logic       upd_valid;
    logic [5:0] upd_index;
    logic       upd_local_correct;
    logic       upd_global_correct;

    logic       out_valid;
    logic       use_global;
    logic       taken;
    logic [1:0] ctr;

    logic       out_valid3;
    logic       use_global3;
    logic       taken3;
    logic [2:0] ctr3;

    int n_vec;
    int n_err;

    tournament_chooser_table dut (
        .clk                (clk),
        .rst                (rst),
        .pred_valid         (pred_valid),
        .pred_index         (pred_index),
        .local_taken        (local_taken),
        .global_taken       (global_taken),
        .pred_out_valid     (out_valid),
        .pred_use_global    (use_global),
        .pred_taken         (taken),
        .pred_ctr           (ctr),
        .upd_valid          (upd_valid),
        .upd_index          (upd_index),
        .upd_local_correct  (upd_local_correct),
        .upd_global_correct (upd_global_correct)
    );

    tournament_chooser_table #(
        .CTR_BITS(3)
    ) dut3 (
        .clk                (clk),
        .rst                (rst),
        .pred_valid         (pred_valid),
        .pred_index         (pred_index),
        .local_taken        (local_taken),
        .global_taken       (global_taken),
        .pred_out_valid     (out_valid3),
        .pred_use_global    (use_global3),
        .pred_taken         (taken3),
        .pred_ctr           (ctr3),
        .upd_valid          (upd_valid),
        .upd_index          (upd_index),
        .upd_local_correct  (upd_local_correct),
        .upd_global_correct (upd_global_correct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic pv, input int pidx, input logic lt, input logic gt,
                        input logic uv, input int uidx, input logic lc, input logic gc);
        pred_valid         = pv;
        pred_index         = 6'(pidx);
        local_taken        = lt;
        global_taken       = gt;
        upd_valid          = uv;
        upd_index          = 6'(uidx);
        upd_local_correct  = lc;
        upd_global_correct = gc;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input int idx);
        step(1'b1, idx, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic train(input int idx, input logic lc, input logic gc);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, idx, lc, gc);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        step(1'b1, 5, 1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b1);
        check_val("rst_valid", int'(out_valid), 0);
        check_val("rst_ctr", int'(ctr), 0);
        check_val("rst_use_global", int'(use_global), 0);
        check_val("rst_taken", int'(taken), 0);
        rst = 1'b0;

        // Default counter value is weakly local.
        lookup(5);
        check_val("init_valid", int'(out_valid), 1);
        check_val("init_ctr", int'(ctr), 1);
        check_val("init_use_global", int'(use_global), 0);
        check_val("init_taken", int'(taken), 1);

        // Idle cycle: valid drops, decision outputs hold.
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check_val("idle_valid", int'(out_valid), 0);
        check_val("idle_hold_ctr", int'(ctr), 1);
        check_val("idle_hold_taken", int'(taken), 1);

        for (int i = 0; i < 3; i++) train(5, 1'b0, 1'b1);
        lookup(5);
        check_val("glob_ctr", int'(ctr), 3);
        check_val("glob_use_global", int'(use_global), 1);
        check_val("glob_taken", int'(taken), 0);
        train(5, 1'b0, 1'b1);
        lookup(5);
        check_val("glob_sat_ctr", int'(ctr), 3);

        train(7, 1'b1, 1'b1);
        lookup(7);
        check_val("agree_ok_ctr", int'(ctr), 1);
        train(7, 1'b0, 1'b0);
        lookup(7);
        check_val("agree_bad_ctr", int'(ctr), 1);

        // Forwarding: lookup and update of the same entry in one cycle.
        step(1'b1, 9, 1'b1, 1'b0, 1'b1, 9, 1'b0, 1'b1);
        check_val("fwd_ctr", int'(ctr), 2);
        check_val("fwd_use_global", int'(use_global), 1);
        check_val("fwd_taken", int'(taken), 0);
        lookup(10);
        check_val("iso_ctr", int'(ctr), 1);
        lookup(9);
        check_val("fwd_stored_ctr", int'(ctr), 2);
        // Different-index update alongside a lookup is independent.
        step(1'b1, 9, 1'b1, 1'b0, 1'b1, 11, 1'b1, 1'b0);
        check_val("indep_ctr", int'(ctr), 2);
        lookup(11);
        check_val("indep_upd_ctr", int'(ctr), 0);
        lookup(11);
        check_val("local_sat_ctr", int'(ctr), 0);

        // Mid-stream reset discards the lookup and any training.
        train(3, 1'b0, 1'b1);
        train(3, 1'b0, 1'b1);
        lookup(3);
        check_val("pre_rst_ctr", int'(ctr), 3);
        rst = 1'b1;
        step(1'b1, 3, 1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b1);
        check_val("mid_rst_valid", int'(out_valid), 0);
        check_val("mid_rst_ctr", int'(ctr), 0);
        rst = 1'b0;
        lookup(3);
        check_val("post_rst_ctr", int'(ctr), 1);
        check_val("post_rst_valid", int'(out_valid), 1);
        lookup(5);
        check_val("post_rst_idx5", int'(ctr), 1);

        // 3-bit instance: starts at 3 and walks down to a floor of 0.
        lookup(0);
        check_val("c3_init_ctr", int'(ctr3), 3);
        check_val("c3_init_use_global", int'(use_global3), 0);
        begin
            int exp3 [5];
            exp3 = '{2, 1, 0, 0, 0};
            for (int i = 0; i < 5; i++) begin
                step(1'b1, 0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0);
                check_val($sformatf("c3_local_step%0d", i), int'(ctr3), exp3[i]);
                check_val($sformatf("c3_use_global%0d", i), int'(use_global3), 0);
            end
        end
        lookup(0);
        check_val("c3_final_ctr", int'(ctr3), 0);
        check_val("c3_final_taken", int'(taken3), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
